pc_fetch_stage: RTL and testbench

//  IF stage directly downstream of the PC select mux. Holds the architectural PC, consumes the
//  mux's next-PC, and returns PC+4 as the mux's sequential input. Issues instruction-memory

---
 rtl/pipe_pkg.sv | 14 +
 rtl/ifid_reg.sv | 55 +++++
 rtl/pc_fetch_stage.sv | 104 ++++++++++
 tb/tb_pc_fetch_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the fetch-stage state encoding.
package pipe_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned INSTR_W   = 32;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    ST_BOOT  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load on accepted fetch, flush to NOP, otherwise hold.
module ifid_reg #(
  parameter int unsigned        ADDR_W    = pipe_pkg::ADDR_W,
  parameter int unsigned        INSTR_W   = pipe_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic               valid_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o
);

  logic [ADDR_W-1:0]  pc_d,    pc_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic               valid_d, valid_q;

  // Flush still captures the PC of an accepted fetch; only the payload is squashed.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (load_i) begin
      pc_d    = pc_i;
      valid_d = valid_i;
      instr_d = valid_i ? instr_i : NOP_INSTR;
    end
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// IF stage: architectural PC, imem request handshake, pending-redirect capture and IF/ID fill.
module pc_fetch_stage #(
  parameter int unsigned        ADDR_W    = pipe_pkg::ADDR_W,
  parameter int unsigned        INSTR_W   = pipe_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC  = pipe_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_next_i,
  input  logic               redirect_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               imem_ready_i,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [ADDR_W-1:0]  pc_plus4_o,
  output logic [ADDR_W-1:0]  ifid_pc_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic               ifid_valid_o
);

  import pipe_pkg::*;

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              pend_d, pend_q;
  logic [ADDR_W-1:0] pend_tgt_d, pend_tgt_q;
  logic              accept;
  logic              ifid_valid_in;
  logic [ADDR_W-1:0] pc_sel;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    imem_req_o = (state_q == ST_FETCH);
  end

  assign accept = (state_q == ST_FETCH) && imem_ready_i && !stall_i;

  // A redirect seen while the fetch was outstanding overrides the mux's sequential PC.
  always_comb begin
    pc_sel        = pend_q ? pend_tgt_q : pc_next_i;
    ifid_valid_in = !(flush_i || redirect_i || pend_q);
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
    if (accept) begin
      pc_d   = pc_sel & ~ADDR_W'(3);
      pend_d = 1'b0;
    end else if (redirect_i) begin
      pend_d     = 1'b1;
      pend_tgt_d = pc_next_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  ifid_reg #(
    .ADDR_W    (ADDR_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .flush_i (flush_i),
    .pc_i    (pc_q),
    .instr_i (imem_rdata_i),
    .valid_i (ifid_valid_in),
    .pc_o    (ifid_pc_o),
    .instr_o (ifid_instr_o),
    .valid_o (ifid_valid_o)
  );

  assign pc_o        = pc_q;
  assign imem_addr_o = pc_q;
  assign pc_plus4_o  = pc_q + ADDR_W'(4);

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: boot, stall, wait-state redirect, flush, wrap, reset mid-fetch.
module tb_pc_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, redirect, stall, flush, ready;
  logic [31:0] tgt, pc_next, rdata;
  logic        req, ifid_valid;
  logic [31:0] addr, pc, pc_plus4, ifid_pc, ifid_instr;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  // PC mux model and instruction memory model (instruction = address ^ KEY).
  assign pc_next = redirect ? tgt : pc_plus4;
  assign rdata   = addr ^ KEY;

  pc_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .pc_next_i    (pc_next),
    .redirect_i   (redirect),
    .stall_i      (stall),
    .flush_i      (flush),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_rdata_i (rdata),
    .imem_ready_i (ready),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .ifid_pc_o    (ifid_pc),
    .ifid_instr_o (ifid_instr),
    .ifid_valid_o (ifid_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; flush = 1'b0; ready = 1'b1; tgt = '0;

    // 1: reset and boot with ready always high
    step(); step();
    chk("rst_pc",    pc,         32'h0);
    chk("rst_req",   {31'b0, req}, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("rst_instr", ifid_instr, NOP);
    chk("rst_ifpc",  ifid_pc,    32'h0);
    rst = 1'b0;
    step();
    chk("boot_req",   {31'b0, req}, 32'h1);
    chk("boot_addr",  addr,         32'h0);
    chk("boot_valid", {31'b0, ifid_valid}, 32'h0);
    step();
    chk("f0_addr",  addr,       32'h4);
    chk("f0_valid", {31'b0, ifid_valid}, 32'h1);
    chk("f0_ifpc",  ifid_pc,    32'h0);
    chk("f0_instr", ifid_instr, 32'hA5A5_0000);
    step();
    chk("f1_addr",  addr,       32'h8);
    chk("f1_ifpc",  ifid_pc,    32'h4);
    chk("f1_instr", ifid_instr, 32'hA5A5_0004);

    // 2: stall three cycles at PC 8
    stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk("stall_pc",    pc,      32'h8);
      chk("stall_ifpc",  ifid_pc, 32'h4);
      chk("stall_req",   {31'b0, req}, 32'h1);
      chk("stall_valid", {31'b0, ifid_valid}, 32'h1);
    end
    stall = 1'b0;
    step();
    chk("unstall_ifpc",  ifid_pc,    32'h8);
    chk("unstall_instr", ifid_instr, 32'hA5A5_0008);
    chk("unstall_pc",    pc,         32'hC);
    step();
    chk("seq_pc", pc, 32'h10);

    // 3: four wait states at 0x10, redirect to 0x100 in the second
    ready = 1'b0;
    step();
    redirect = 1'b1; tgt = 32'h100;
    step();
    redirect = 1'b0;
    step(); step();
    chk("wait_pc",   pc,      32'h10);
    chk("wait_ifpc", ifid_pc, 32'hC);
    ready = 1'b1;
    step();
    chk("redir_valid", {31'b0, ifid_valid}, 32'h0);
    chk("redir_instr", ifid_instr, NOP);
    chk("redir_ifpc",  ifid_pc,    32'h10);
    chk("redir_addr",  addr,       32'h100);
    step();
    chk("tgt_valid", {31'b0, ifid_valid}, 32'h1);
    chk("tgt_instr", ifid_instr, 32'hA5A5_0100);
    chk("tgt_pc",    pc,         32'h104);

    // 4: flush during stall
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_valid", {31'b0, ifid_valid}, 32'h0);
    chk("flush_instr", ifid_instr, NOP);
    chk("flush_pc",    pc,         32'h104);
    chk("flush_ifpc",  ifid_pc,    32'h100);
    flush = 1'b0;
    step();
    chk("flush_hold", {31'b0, ifid_valid}, 32'h0);
    stall = 1'b0;
    step();
    chk("postflush_ifpc",  ifid_pc, 32'h104);
    chk("postflush_valid", {31'b0, ifid_valid}, 32'h1);
    chk("postflush_pc",    pc,      32'h108);

    // 5: wrap and low-bit masking
    redirect = 1'b1; tgt = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc",    pc,       32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4, 32'h0);
    chk("wrap_valid", {31'b0, ifid_valid}, 32'h0);
    redirect = 1'b0;
    step();
    chk("wrapped_pc",    pc,         32'h0);
    chk("wrapped_ifpc",  ifid_pc,    32'hFFFF_FFFC);
    chk("wrapped_instr", ifid_instr, 32'h5A5A_FFFC);
    redirect = 1'b1; tgt = 32'h103;
    step();
    chk("mask_pc", pc, 32'h100);
    redirect = 1'b0;

    // 6: reset with a fetch outstanding and ready in the same cycle
    ready = 1'b0;
    step();
    rst = 1'b1; ready = 1'b1;
    step();
    chk("midrst_pc",    pc,           32'h0);
    chk("midrst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("midrst_req",   {31'b0, req}, 32'h0);
    chk("midrst_instr", ifid_instr,   NOP);
    rst = 1'b0;
    step();
    chk("reboot_req",   {31'b0, req}, 32'h1);
    chk("reboot_valid", {31'b0, ifid_valid}, 32'h0);
    chk("reboot_addr",  addr,         32'h0);
    step();
    chk("reboot_ifpc",  ifid_pc, 32'h0);
    chk("reboot_vld",   {31'b0, ifid_valid}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
